// File: rtl/tone_mixer_axis.sv
// tone_mixer_axis
// Multi-voice tone synthesiser feeding the tx AXI-stream sink of the I2S2
// codec wrapper. Each frame latches the per-voice controls, mixes one sample
// per voice serially, scales the mix, then sends it as a left word followed by
// a right word (last_o set on the right word). Phases advance once per frame.
//
// Optional feature: define MIXER_SATURATE_EN to clamp the raw mix to the
// sample range instead of dividing it by the voice count.
//
// Handshake: a word transfers on a rising edge where valid_o && ready_i.
// valid_o, data_o and last_o are registered and stay stable while
// valid_o=1 and ready_i=0; valid_o only drops after its handshake.
//
// Ports:
//   clk_i      clock (axis domain)
//   reset_i    asynchronous active-high reset
//   fstep_i    per-voice phase increment, voice k at [k*phase_width_p +: phase_width_p]
//   wave_i     per-voice waveform, 00 silent, 01 square, 10 saw, 11 triangle
//   gate_i     per-voice enable
//   ready_i    AXIS sink ready
//   valid_o    AXIS valid
//   data_o     AXIS data, signed mixed sample
//   last_o     AXIS last, 1 on the right-channel word
//   state_dbg  current FSM state (LATCH=0 .. ADVANCE=5)
module tone_mixer_axis #(
   parameter int voices_p      = 4,
   parameter int width_p       = 24,
   parameter int phase_width_p = 32
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic [voices_p*phase_width_p-1:0]   fstep_i,
   input  logic [voices_p*2-1:0]               wave_i,
   input  logic [voices_p-1:0]                 gate_i,
   input  logic                                ready_i,
   output logic                                valid_o,
   output logic [width_p-1:0]                  data_o,
   output logic                                last_o,
   output logic [2:0]                          state_dbg
);

   localparam int lg_c    = $clog2(voices_p);
   localparam int acc_w_c = width_p + lg_c;
   localparam int idx_w_c = (lg_c > 0) ? lg_c : 1;
   localparam logic [idx_w_c-1:0] last_idx_c = idx_w_c'(voices_p - 1);

   typedef enum logic [2:0] {
      LATCH   = 3'd0,
      ACCUM   = 3'd1,
      SCALE   = 3'd2,
      SEND_L  = 3'd3,
      SEND_R  = 3'd4,
      ADVANCE = 3'd5
   } state_t;

   state_t                             state;
   logic [idx_w_c-1:0]                 idx;
   logic [phase_width_p-1:0]           phase [voices_p];
   logic [voices_p*phase_width_p-1:0]  fstep_sh;
   logic [voices_p*2-1:0]              wave_sh;
   logic [voices_p-1:0]                gate_sh;
   logic signed [acc_w_c-1:0]          acc;
   logic signed [width_p-1:0]          cur_sample;
   logic [width_p-1:0]                 mix;

   assign state_dbg = state;

   // p is the top width_p bits of the phase; its MSB is the half-cycle flag.
   function automatic logic signed [width_p-1:0] voice_sample(
      input logic [width_p-1:0] p,
      input logic [1:0]         wave,
      input logic               gate
   );
      logic               m;
      logic [width_p-1:0] t;
      m = p[width_p-1];
      // Triangle folds the second half-cycle back down, doubling the slope.
      t = m ? {~p[width_p-2:0], 1'b0} : {p[width_p-2:0], 1'b0};
      voice_sample = '0;
      if (gate) begin
         case (wave)
            2'b01:   voice_sample = m ? {1'b1, {(width_p-1){1'b0}}}
                                      : {1'b0, {(width_p-1){1'b1}}};
            2'b10:   voice_sample = {~m, p[width_p-2:0]};
            2'b11:   voice_sample = {~t[width_p-1], t[width_p-2:0]};
            default: voice_sample = '0;
         endcase
      end
   endfunction

   always_comb begin
      cur_sample = voice_sample(phase[idx][phase_width_p-1 -: width_p],
                                wave_sh[idx*2 +: 2], gate_sh[idx]);
   end

`ifdef MIXER_SATURATE_EN
   localparam logic signed [acc_w_c-1:0] sat_max_c =
      {{(acc_w_c-width_p+1){1'b0}}, {(width_p-1){1'b1}}};
   localparam logic signed [acc_w_c-1:0] sat_min_c =
      {{(acc_w_c-width_p+1){1'b1}}, {(width_p-1){1'b0}}};

   always_comb begin
      mix = width_p'(acc);
      if (acc > sat_max_c)      mix = width_p'(sat_max_c);
      else if (acc < sat_min_c) mix = width_p'(sat_min_c);
   end
`else
   // Divide by the voice count so a full-scale mix can never wrap.
   always_comb begin
      mix = width_p'(acc >>> lg_c);
   end
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state    <= LATCH;
         idx      <= '0;
         acc      <= '0;
         valid_o  <= 1'b0;
         data_o   <= '0;
         last_o   <= 1'b0;
         fstep_sh <= '0;
         wave_sh  <= '0;
         gate_sh  <= '0;
         for (int k = 0; k < voices_p; k++) phase[k] <= '0;
      end else begin
         case (state)
            LATCH: begin
               fstep_sh <= fstep_i;
               wave_sh  <= wave_i;
               gate_sh  <= gate_i;
               acc      <= '0;
               idx      <= '0;
               state    <= ACCUM;
            end
            ACCUM: begin
               acc <= acc + acc_w_c'(cur_sample);
               idx <= idx + idx_w_c'(1);
               if (idx == last_idx_c) state <= SCALE;
            end
            SCALE: begin
               data_o  <= mix;
               valid_o <= 1'b1;
               last_o  <= 1'b0;
               state   <= SEND_L;
            end
            SEND_L: begin
               if (ready_i) begin
                  last_o <= 1'b1;
                  state  <= SEND_R;
               end
            end
            SEND_R: begin
               if (ready_i) begin
                  valid_o <= 1'b0;
                  last_o  <= 1'b0;
                  state   <= ADVANCE;
               end
            end
            ADVANCE: begin
               for (int k = 0; k < voices_p; k++) begin
                  phase[k] <= gate_sh[k] ? phase[k] + fstep_sh[k*phase_width_p +: phase_width_p]
                                         : '0;
               end
               state <= LATCH;
            end
            default: state <= LATCH;
         endcase
      end
   end

endmodule
